jtag_debug_ocimem_ctrl: RTL
===========================

Name: jtag_debug_ocimem_ctrl

Overview:
- System-clock stage directly downstream of the JTAG debug module's sysclk command decoder.
- Consumes jdo and the take_action_ocimem_* / take_no_action_ocimem_a strobes, and performs word reads and writes on the on-chip debug monitor RAM.
- Returns MonDReg, monitor_ready and monitor_error, which the decoder's tck side shifts back out to the host.
- Single clock domain; the upstream decoder has already synchronised all strobes to clk.

Parameters:
ADDR_W, 8, word-address width of the monitor RAM (RAM depth = 2^ADDR_W words of 32 bits)
RD_LAT, 1, RAM read latency in clk cycles from the ram_re cycle to valid ram_rdata; legal range 1..3

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
jdo  input  38  command/data word from the decoder, valid in the cycle a strobe is high
take_action_ocimem_a  input  1  one-cycle strobe: address/control command
take_action_ocimem_b  input  1  one-cycle strobe: write command
take_no_action_ocimem_a  input  1  one-cycle strobe: read-next command
ram_addr  output  ADDR_W  monitor RAM word address
ram_wdata  output  32  monitor RAM write data
ram_we  output  1  monitor RAM write enable, one-cycle pulse
ram_re  output  1  monitor RAM read enable, one-cycle pulse
ram_rdata  input  32  monitor RAM read data
MonAReg  output  ADDR_W  current word-address register
MonDReg  output  32  last read data, or last written data
monitor_ready  output  1  high when idle and able to accept a command
monitor_error  output  1  sticky flag: a command arrived while busy

Behaviour:
- Reset (asynchronous, active-high) clears all state: state=IDLE, MonAReg=0, MonDReg=0, monitor_ready=1, monitor_error=0, ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0. Reset asserted mid-operation abandons the access with no partial update; the next access starts from IDLE.
- All outputs are registered. States: IDLE, RD, RD_WAIT, WR.
- Strobe priority when more than one is high in the same cycle: take_action_ocimem_a, then take_action_ocimem_b, then take_no_action_ocimem_a. Only the winner executes and no error is raised.
- In IDLE, take_action_ocimem_a:
  - MonAReg <= jdo[ADDR_W+1:2].
  - If jdo[35]=1, monitor_error <= 0.
  - If jdo[34]=1, go to RD using the new address, with no post-increment. Otherwise stay in IDLE and monitor_ready stays 1.
- In IDLE, take_no_action_ocimem_a (read-next): go to RD at MonAReg; MonAReg increments after capture.
- In IDLE, take_action_ocimem_b (write): go to WR. On that edge: ram_we<=1, ram_addr<=MonAReg, ram_wdata<=jdo[34:3], MonDReg<=jdo[34:3], monitor_ready<=0.
- WR lasts 1 cycle. Next edge: ram_we<=0, MonAReg<=MonAReg+1, monitor_ready<=1, state IDLE.
- Entering RD (command edge E0): ram_re<=1, ram_addr<=target address, monitor_ready<=0, latency counter<=0.
- Next edge: ram_re<=0, state RD_WAIT.
- RD_WAIT: the counter increments each edge. When the counter reaches RD_LAT-1, ram_rdata is sampled into MonDReg on that edge, monitor_ready<=1, state IDLE.
- MonAReg increments on the capture edge only for read-next.
- With RD_LAT=1, MonDReg updates at E0+2 and monitor_ready is low for 2 cycles.
- Any strobe that arrives while the state is not IDLE is ignored: no RAM access, no register change, and monitor_error<=1 (sticky). It is cleared only by take_action_ocimem_a with jdo[35]=1 in IDLE, or by reset.
- MonAReg increments modulo 2^ADDR_W: the maximum address wraps to 0 with no error.
- ram_we and ram_re are never high in the same cycle; each is high for exactly one cycle per access.

Test Plan:
- Reset release -> monitor_ready=1, monitor_error=0, MonDReg=0, MonAReg=0, ram_we=ram_re=0.
- Set address then read: ocimem_a with jdo[9:2]=8'h10 and jdo[34]=1, RAM[0x10]=32'hDEADBEEF, RD_LAT=1 -> ram_re pulses with ram_addr=0x10; MonDReg=DEADBEEF two edges after the strobe; MonAReg stays 0x10.
- Write burst: address 0xFE, then ocimem_b with jdo[34:3]=32'h12345678, then 32'hCAFEF00D -> ram_we pulses at addr 0xFE then 0xFF; MonAReg ends at 0x00 (wrap); MonDReg=CAFEF00D.
- Read-next sequence: three no_action_a strobes from address 0x20 -> reads at 0x20, 0x21, 0x22; MonAReg=0x23 at end; each read is preceded by monitor_ready falling.
- Busy collision: ocimem_b one cycle after a read-next strobe (RD_LAT=3) -> no ram_we, monitor_error=1 until ocimem_a with jdo[35]=1; read data is still captured correctly.
- Reset asserted during RD_WAIT -> ram_re=0, monitor_ready=1, MonDReg=0 immediately without a clock edge; a subsequent read completes normally.

Source files
------------

// File: rtl/jtag_debug_ocimem_ctrl.sv
// System-clock side of the JTAG debug monitor-RAM access path: turns decoded
// ocimem strobes into single-word RAM reads/writes and reports MonDReg/status.
module jtag_debug_ocimem_ctrl #(
   parameter int ADDR_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic              ram_we,
   output logic              ram_re,
   input  logic [31:0]       ram_rdata,
   output logic [ADDR_W-1:0] MonAReg,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error
);
   typedef enum logic [1:0] {IDLE, RD, RD_WAIT, WR} state_t;

   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

   state_t            state_reg, state_next;
   logic [1:0]        cnt_reg, cnt_next;
   logic              inc_reg, inc_next;
   logic [ADDR_W-1:0] ram_addr_next, mon_a_next;
   logic [31:0]       ram_wdata_next, mon_d_next;
   logic              ram_we_next, ram_re_next, ready_next, error_next;
   logic              any_strobe;
   logic              jdo_unused;

   assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
   assign jdo_unused = ^{jdo[37:36], jdo[1:0]};

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      inc_next       = inc_reg;
      ram_addr_next  = ram_addr;
      ram_wdata_next = ram_wdata;
      ram_we_next    = 1'b0;
      ram_re_next    = 1'b0;
      mon_a_next     = MonAReg;
      mon_d_next     = MonDReg;
      ready_next     = monitor_ready;
      error_next     = monitor_error;

      case (state_reg)
         IDLE: begin
            if (take_action_ocimem_a) begin
               mon_a_next = jdo[ADDR_W+1:2];
               if (jdo[35]) error_next = 1'b0;
               if (jdo[34]) begin
                  state_next    = RD;
                  ram_re_next   = 1'b1;
                  ram_addr_next = jdo[ADDR_W+1:2];
                  ready_next    = 1'b0;
                  cnt_next      = '0;
                  inc_next      = 1'b0;
               end
            end else if (take_action_ocimem_b) begin
               state_next     = WR;
               ram_we_next    = 1'b1;
               ram_addr_next  = MonAReg;
               ram_wdata_next = jdo[34:3];
               mon_d_next     = jdo[34:3];
               ready_next     = 1'b0;
            end else if (take_no_action_ocimem_a) begin
               state_next    = RD;
               ram_re_next   = 1'b1;
               ram_addr_next = MonAReg;
               ready_next    = 1'b0;
               cnt_next      = '0;
               inc_next      = 1'b1;
            end
         end
         RD: state_next = RD_WAIT;
         RD_WAIT: begin
            if (cnt_reg == LAT_LAST) begin
               // capture edge; only read-next advances the address
               mon_d_next = ram_rdata;
               ready_next = 1'b1;
               state_next = IDLE;
               if (inc_reg) mon_a_next = MonAReg + ADDR_W'(1);
            end else begin
               cnt_next = cnt_reg + 2'd1;
            end
         end
         WR: begin
            mon_a_next = MonAReg + ADDR_W'(1);
            ready_next = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      if (state_reg != IDLE && any_strobe) error_next = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         inc_reg       <= 1'b0;
         ram_addr      <= '0;
         ram_wdata     <= '0;
         ram_we        <= 1'b0;
         ram_re        <= 1'b0;
         MonAReg       <= '0;
         MonDReg       <= '0;
         monitor_ready <= 1'b1;
         monitor_error <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         inc_reg       <= inc_next;
         ram_addr      <= ram_addr_next;
         ram_wdata     <= ram_wdata_next;
         ram_we        <= ram_we_next;
         ram_re        <= ram_re_next;
         MonAReg       <= mon_a_next;
         MonDReg       <= mon_d_next;
         monitor_ready <= ready_next;
         monitor_error <= error_next;
      end
   end
endmodule
